// File: rtl/maze_pkg.sv
// Shared definitions for the maze generator sequencer.
// Contents: cell codes written to the maze RAM, sequencer state enum,
// maze geometry constants and a helper converting a 3-bit dimension select
// into a cell count.
package maze_pkg;

  localparam int MAZE_COLS = 64;
  localparam int MAZE_ROWS = 64;
  localparam int ADDR_W    = 12;

  typedef enum logic [1:0] {
    CELL_OUT      = 2'b00,
    CELL_FRONTIER = 2'b01,
    CELL_WALL     = 2'b10,
    CELL_PATH     = 2'b11
  } cell_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_SEED,
    ST_CARVE,
    ST_DONE,
    ST_ERROR
  } state_e;

  // dimension select 0..7 -> 8..64 cells
  function automatic logic [6:0] dim_cells(input logic [2:0] sel);
    return ({4'd0, sel} + 7'd1) << 3;
  endfunction

endpackage

// File: rtl/maze_gen_ctrl_if.sv
// Bundle of the sequencer's user, RAM and carver signals.
// master : the sequencer (maze_gen_ctrl)
// slave  : the environment (start logic, cell RAM, carver, readers)
interface maze_gen_ctrl_if;
  import maze_pkg::*;

  // user request
  logic              go;
  logic [2:0]        x_dimension;
  logic [2:0]        y_dimension;
  logic [15:0]       seed;
  // cell RAM write port
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [1:0]        mem_wdata;
  // carver handshake
  logic              sel_carver;
  logic              carve_start;
  logic              carve_finish;
  logic              rand_ack;
  logic [1:0]        rand_dir;
  // status
  logic [6:0]        width_cells;
  logic [6:0]        height_cells;
  logic              busy;
  logic              maze_ready;
  logic              timeout_err;

  modport master (
    input  go, x_dimension, y_dimension, seed, carve_finish, rand_ack,
    output mem_we, mem_addr, mem_wdata, sel_carver, carve_start, rand_dir,
           width_cells, height_cells, busy, maze_ready, timeout_err
  );

  modport slave (
    output go, x_dimension, y_dimension, seed, carve_finish, rand_ack,
    input  mem_we, mem_addr, mem_wdata, sel_carver, carve_start, rand_dir,
           width_cells, height_cells, busy, maze_ready, timeout_err
  );

endinterface

// File: rtl/maze_lfsr16.sv
// 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11 (mask 16'hB400).
// Ports: clk, rst_n (async, active low), load_i/seed_i (synchronous load,
// wins over step), step_i (advance one position), lfsr_o (current state).
module maze_lfsr16 #(
  parameter logic [15:0] RESET_VAL = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic [15:0] seed_i,
  input  logic        step_i,
  output logic [15:0] lfsr_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // shift right, fold the tap mask back in when the bit shifted out is 1
  assign lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);

  // NOTE: non-blocking assignment so the register updates from the value
  // it held before the edge, independent of statement ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      lfsr_q <= RESET_VAL;
    else if (load_i) lfsr_q <= seed_i;
    else if (step_i) lfsr_q <= lfsr_d;
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/maze_gen_ctrl.sv
// Maze generation sequencer: clears the 64x64 cell RAM, writes the start
// cell as PATH, then hands the RAM port to the carver, feeding it random
// direction bits until it reports finish (-> maze_ready) or the CARVE-state
// cycle limit expires (-> timeout_err).
// Ports: clk, rst_n (async, active low), bus (maze_gen_ctrl_if.master:
// go/dimensions/seed in, RAM write port out, carver handshake, status out).
// Build option MAZE_CLEAR_ACTIVE_EN: when defined, CLEAR only writes the
// active width_cells x height_cells region instead of all 4096 cells.
module maze_gen_ctrl
  import maze_pkg::*;
#(
  parameter int unsigned    TIMEOUT_CYCLES = 1048575,
  parameter logic [15:0]    LFSR_DEFAULT   = 16'hACE1,
  parameter int unsigned    START_X        = 0,
  parameter int unsigned    START_Y        = 0
) (
  input logic            clk,
  input logic            rst_n,
  maze_gen_ctrl_if.master bus
);

  localparam logic [19:0] TCNT_LAST = 20'(TIMEOUT_CYCLES - 1);

  state_e      state_q;
  logic [5:0]  x_q, y_q;
  logic [5:0]  x_d, y_d;
  logic [19:0] tcnt_q;
  logic [6:0]  width_q, height_q;
  logic        mem_we_q, sel_q, cstart_q, busy_q, ready_q, terr_q;
  logic [1:0]  wdata_q;
  logic        clear_last;
  logic        start;
  logic [15:0] lfsr;

  // a new run may only begin when no run is in flight
  assign start = bus.go &&
                 (state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_ERROR);

  // NOTE: every always_comb output gets a value on every path (defaults
  // first) so no latch is inferred.
  always_comb begin
    clear_last = 1'b0;
    x_d        = x_q;
    y_d        = y_q;
`ifdef MAZE_CLEAR_ACTIVE_EN
    // raster over the active region only; x wraps at width with y+1
    if (x_q == 6'(width_q - 7'd1)) begin
      x_d        = '0;
      y_d        = y_q + 6'd1;
      clear_last = (y_q == 6'(height_q - 7'd1));
    end else begin
      x_d = x_q + 6'd1;
    end
`else
    // full store: {y,x} is a plain 12-bit counter
    {y_d, x_d} = {y_q, x_q} + 12'd1;
    clear_last = &{y_q, x_q};
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      tcnt_q   <= '0;
      width_q  <= 7'd8;
      height_q <= 7'd8;
      mem_we_q <= 1'b0;
      wdata_q  <= CELL_OUT;
      sel_q    <= 1'b0;
      cstart_q <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
      terr_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            state_q  <= ST_CLEAR;
            width_q  <= dim_cells(bus.x_dimension);
            height_q <= dim_cells(bus.y_dimension);
            x_q      <= '0;
            y_q      <= '0;
            mem_we_q <= 1'b1;
            wdata_q  <= CELL_OUT;
            busy_q   <= 1'b1;
            ready_q  <= 1'b0;
            terr_q   <= 1'b0;
          end
        end
        ST_CLEAR: begin
          if (clear_last) begin
            state_q <= ST_SEED;
            x_q     <= 6'(START_X);
            y_q     <= 6'(START_Y);
            wdata_q <= CELL_PATH;
          end else begin
            x_q <= x_d;
            y_q <= y_d;
          end
        end
        ST_SEED: begin
          state_q  <= ST_CARVE;
          mem_we_q <= 1'b0;
          sel_q    <= 1'b1;
          cstart_q <= 1'b1;
          tcnt_q   <= '0;
        end
        ST_CARVE: begin
          // finish wins over a timeout landing in the same cycle
          if (bus.carve_finish) begin
            state_q  <= ST_DONE;
            sel_q    <= 1'b0;
            cstart_q <= 1'b0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b1;
          end else if (tcnt_q == TCNT_LAST) begin
            state_q  <= ST_ERROR;
            sel_q    <= 1'b0;
            cstart_q <= 1'b0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b0;
            terr_q   <= 1'b1;
          end else begin
            tcnt_q <= tcnt_q + 20'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  maze_lfsr16 #(.RESET_VAL(LFSR_DEFAULT)) u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (start),
    .seed_i ((bus.seed == 16'd0) ? LFSR_DEFAULT : bus.seed),
    .step_i (bus.rand_ack && state_q == ST_CARVE),
    .lfsr_o (lfsr)
  );

  assign bus.mem_we       = mem_we_q;
  assign bus.mem_addr     = {y_q, x_q};
  assign bus.mem_wdata    = wdata_q;
  assign bus.sel_carver   = sel_q;
  assign bus.carve_start  = cstart_q;
  assign bus.rand_dir     = lfsr[1:0];
  assign bus.width_cells  = width_q;
  assign bus.height_cells = height_q;
  assign bus.busy         = busy_q;
  assign bus.maze_ready   = ready_q;
  assign bus.timeout_err  = terr_q;

endmodule

// File: tb/tb_maze_gen_ctrl.sv
// Directed bench for maze_gen_ctrl. dut_a uses the default timeout,
// dut_b a 50-cycle timeout. Inputs change 1 ns after a rising edge and
// outputs are sampled at that same point.
module tb_maze_gen_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  maze_gen_ctrl_if ifa ();
  maze_gen_ctrl_if ifb ();

  maze_gen_ctrl dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  maze_gen_ctrl #(.TIMEOUT_CYCLES(50)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  int n_checks = 0;
  int n_errors = 0;

`ifdef MAZE_CLEAR_ACTIVE_EN
  localparam bit ACTIVE_CLR = 1'b1;
`else
  localparam bit ACTIVE_CLR = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] galois_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  // expected address of the i-th CLEAR write for a w-cell-wide region
  function automatic logic [11:0] clr_addr(input int i, input int w);
    if (ACTIVE_CLR) return {6'(i / w), 6'(i % w)};
    return 12'(i);
  endfunction

  function automatic int clr_len(input int w, input int h);
    return ACTIVE_CLR ? w * h : 4096;
  endfunction

  task automatic check_clear(input string tag, input int w, input int h, input int go_at);
    int bad = 0;
    for (int i = 0; i < clr_len(w, h); i++) begin
      if (ifa.mem_we !== 1'b1 || ifa.mem_addr !== clr_addr(i, w) ||
          ifa.mem_wdata !== 2'b00 || ifa.busy !== 1'b1) bad++;
      ifa.go = (i == go_at);
      tick();
    end
    ifa.go = 1'b0;
    check(tag, 32'(bad), 32'd0);
  endtask

  task automatic b_wait_carve(input string tag);
    for (int k = 0; k < 5000 && ifb.carve_start !== 1'b1; k++) tick();
    check(tag, 32'(ifb.carve_start), 32'd1);
  endtask

  initial begin
    logic [15:0] model;
    int c;
    int ridx;
    ifa.go = 0; ifa.x_dimension = 0; ifa.y_dimension = 0; ifa.seed = 0;
    ifa.carve_finish = 0; ifa.rand_ack = 0;
    ifb.go = 0; ifb.x_dimension = 0; ifb.y_dimension = 0; ifb.seed = 0;
    ifb.carve_finish = 0; ifb.rand_ack = 0;

    // ---- reset state
    tick(); tick();
    check("rst_busy", 32'(ifa.busy), 0);
    check("rst_we", 32'(ifa.mem_we), 0);
    check("rst_addr", 32'(ifa.mem_addr), 0);
    check("rst_ready", 32'(ifa.maze_ready), 0);
    check("rst_width", 32'(ifa.width_cells), 8);
    check("rst_height", 32'(ifa.height_cells), 8);
    check("rst_lfsr", 32'(dut_a.u_lfsr.lfsr_o), 32'hACE1);
    rst_n = 1'b1;
    tick();

    // ---- test 1: go with 32x16, seed 0
    ifa.go = 1; ifa.x_dimension = 3; ifa.y_dimension = 1; ifa.seed = 0;
    tick();
    ifa.go = 0;
    check("t1_width", 32'(ifa.width_cells), 32);
    check("t1_height", 32'(ifa.height_cells), 16);
    check("t1_sel_clear", 32'(ifa.sel_carver), 0);
    // includes a go pulse mid-CLEAR that must be ignored
    check_clear("t1_clear_seq", 32, 16, 10);
    check("t1_seed_we", 32'(ifa.mem_we), 1);
    check("t1_seed_addr", 32'(ifa.mem_addr), 0);
    check("t1_seed_data", 32'(ifa.mem_wdata), 3);
    tick(); c = 1;
    check("t1_cstart", 32'(ifa.carve_start), 1);
    check("t1_sel", 32'(ifa.sel_carver), 1);
    check("t1_we_off", 32'(ifa.mem_we), 0);
    check("t1_lfsr", 32'(dut_a.u_lfsr.lfsr_o), 32'hACE1);
    check("t1_dir", 32'(ifa.rand_dir), 1);

    // ---- test 2: LFSR stepping from ACE1
    model = 16'hACE1;
    ifa.rand_ack = 1; tick(); c++; ifa.rand_ack = 0; model = galois_next(model);
    check("t2_step1", 32'(dut_a.u_lfsr.lfsr_o), 32'(model));
    check("t2_step1_hex", 32'(dut_a.u_lfsr.lfsr_o), 32'hE270);
    tick(); c++;
    check("t2_hold", 32'(dut_a.u_lfsr.lfsr_o), 32'(model));
    ifa.rand_ack = 1; tick(); c++; model = galois_next(model);
    check("t2_step2", 32'(dut_a.u_lfsr.lfsr_o), 32'(model));
    tick(); c++; ifa.rand_ack = 0; model = galois_next(model);
    check("t2_step3", 32'(dut_a.u_lfsr.lfsr_o), 32'(model));
    check("t2_dir3", 32'(ifa.rand_dir), 32'(model[1:0]));

    // ---- test 5a: go during CARVE is ignored
    ifa.go = 1; tick(); c++; ifa.go = 0;
    check("t5_go_carve_cs", 32'(ifa.carve_start), 1);
    check("t5_go_carve_lfsr", 32'(dut_a.u_lfsr.lfsr_o), 32'(model));

    // ---- test 3: finish raised in CARVE cycle 100
    while (c < 100) begin tick(); c++; end
    check("t3_still_carve", 32'(ifa.carve_start), 1);
    ifa.carve_finish = 1; tick(); ifa.carve_finish = 0;
    check("t3_ready", 32'(ifa.maze_ready), 1);
    check("t3_busy", 32'(ifa.busy), 0);
    check("t3_sel", 32'(ifa.sel_carver), 0);
    check("t3_cstart", 32'(ifa.carve_start), 0);
    ifa.rand_ack = 1; tick(); ifa.rand_ack = 0;
    check("t3_ready_held", 32'(ifa.maze_ready), 1);
    check("t3_lfsr_hold_done", 32'(dut_a.u_lfsr.lfsr_o), 32'(model));

    // restart from DONE, 8x8, non-zero seed
    ifa.go = 1; ifa.x_dimension = 0; ifa.y_dimension = 0; ifa.seed = 16'h0003;
    tick(); ifa.go = 0;
    check("t3_restart_ready", 32'(ifa.maze_ready), 0);
    check("t3_restart_busy", 32'(ifa.busy), 1);
    check("t3_restart_we", 32'(ifa.mem_we), 1);
    check("t3_restart_w", 32'(ifa.width_cells), 8);
    check("t3_seed_load", 32'(dut_a.u_lfsr.lfsr_o), 32'h0003);

    // ---- test 5b: asynchronous reset in the middle of CLEAR
    ridx = ACTIVE_CLR ? 30 : 2000;
    for (int i = 0; i < ridx; i++) tick();
    check("t5_addr_at_rst", 32'(ifa.mem_addr), 32'(clr_addr(ridx, 8)));
    rst_n = 1'b0; #1;
    check("t5_rst_we", 32'(ifa.mem_we), 0);
    check("t5_rst_busy", 32'(ifa.busy), 0);
    check("t5_rst_addr", 32'(ifa.mem_addr), 0);
    check("t5_rst_ready", 32'(ifa.maze_ready), 0);
    check("t5_rst_lfsr", 32'(dut_a.u_lfsr.lfsr_o), 32'hACE1);
    tick(); rst_n = 1'b1; tick(); tick();
    check("t5_idle_we", 32'(ifa.mem_we), 0);
    check("t5_idle_ready", 32'(ifa.maze_ready), 0);

`ifdef MAZE_CLEAR_ACTIVE_EN
    // ---- test 6: active-region clear of 8x8, 7 -> 64 boundary
    ifa.go = 1; ifa.x_dimension = 0; ifa.y_dimension = 0; ifa.seed = 0;
    tick(); ifa.go = 0;
    for (int i = 0; i < 7; i++) tick();
    check("t6_addr7", 32'(ifa.mem_addr), 7);
    tick();
    check("t6_addr64", 32'(ifa.mem_addr), 64);
    for (int i = 8; i < 64; i++) tick();
    check("t6_seed_after_64", 32'(ifa.mem_wdata), 3);
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
`endif

    // ---- test 4: 50-cycle timeout on dut_b
    ifb.go = 1; tick(); ifb.go = 0;
    b_wait_carve("t4_enter_carve");
    for (int i = 1; i < 50; i++) tick();
    check("t4_cycle50_carve", 32'(ifb.carve_start), 1);
    check("t4_cycle50_terr", 32'(ifb.timeout_err), 0);
    tick();
    check("t4_terr", 32'(ifb.timeout_err), 1);
    check("t4_busy", 32'(ifb.busy), 0);
    check("t4_sel", 32'(ifb.sel_carver), 0);
    check("t4_ready", 32'(ifb.maze_ready), 0);
    // restart from ERROR; finish lands in the 50th cycle
    ifb.go = 1; tick(); ifb.go = 0;
    check("t4_terr_cleared", 32'(ifb.timeout_err), 0);
    b_wait_carve("t4_reenter_carve");
    for (int i = 1; i < 50; i++) tick();
    ifb.carve_finish = 1; tick(); ifb.carve_finish = 0;
    check("t4_finish_wins_ready", 32'(ifb.maze_ready), 1);
    check("t4_finish_wins_terr", 32'(ifb.timeout_err), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
